// File: rtl/sram_controller_if.sv
// sram_controller_if: CPU data/fetch ports and SRAM pins of the shared-SRAM controller
interface sram_controller_if #(parameter int ADDR_W = 18);
   logic [15:0] Aaddr, Baddr, dataWrite, AmemRead, BmemRead;
   logic [1:0] rw;
   logic stall;
   logic [ADDR_W-1:0] ramAddr;
   logic [15:0] ramDataOut, ramDataIn;
   logic ramDataOe, ramCe_n, ramOe_n, ramWe_n;
   modport master (
      output Aaddr, Baddr, dataWrite, rw, ramDataIn,
      input  AmemRead, BmemRead, stall, ramAddr, ramDataOut, ramDataOe, ramCe_n, ramOe_n, ramWe_n
   );
   modport slave (
      input  Aaddr, Baddr, dataWrite, rw, ramDataIn,
      output AmemRead, BmemRead, stall, ramAddr, ramDataOut, ramDataOe, ramCe_n, ramOe_n, ramWe_n
   );
endinterface

// File: rtl/sram_controller.sv
// sram_controller: serialises the CPU data-port access then the instruction fetch onto one async SRAM
module sram_controller #(
   parameter int ADDR_W = 18,
   parameter int WRITE_PULSE = 1
) (
   input logic clk,
   input logic rst,
   sram_controller_if.slave bus
);
   typedef enum logic [2:0] {IDLE, A_RD, A_WS, A_WP, A_WH, B_RD, DONE} state_t;
   state_t state, stateNext;
   logic [3:0] cnt, cntNext;
   logic [15:0] aLat, bLat, dLat, aSel, bSel, dSel;
   logic [ADDR_W-1:0] ramAddr, ramAddrNext;
   logic [15:0] ramDataOut, ramDataOutNext, AmemRead, BmemRead;
   logic ramDataOe, ramCe_n, ramOe_n, ramWe_n, stall;
   logic ramDataOeNext, ramCe_nNext, ramOe_nNext, ramWe_nNext, stallNext;
   logic aNext, wrNext, rdNext;
   assign bus.ramAddr = ramAddr;
   assign bus.ramDataOut = ramDataOut;
   assign bus.ramDataOe = ramDataOe;
   assign bus.ramCe_n = ramCe_n;
   assign bus.ramOe_n = ramOe_n;
   assign bus.ramWe_n = ramWe_n;
   assign bus.stall = stall;
   assign bus.AmemRead = AmemRead;
   assign bus.BmemRead = BmemRead;
   // next state plus the pin values of that state, so every output is registered on the entering edge
   always_comb begin
      stateNext = state;
      cntNext = cnt;
      aSel = state == IDLE ? bus.Aaddr : aLat;
      bSel = state == IDLE ? bus.Baddr : bLat;
      dSel = state == IDLE ? bus.dataWrite : dLat;
      case (state)
         IDLE: stateNext = bus.rw == 2'b01 ? A_RD : bus.rw == 2'b10 ? A_WS : B_RD;
         A_RD: stateNext = B_RD;
         A_WS: begin
            stateNext = A_WP;
            cntNext = 4'(WRITE_PULSE - 1);
         end
         A_WP: begin
            stateNext = cnt != 4'd0 ? A_WP : A_WH;
            cntNext = cnt != 4'd0 ? cnt - 4'd1 : cnt;
         end
         A_WH: stateNext = B_RD;
         B_RD: stateNext = DONE;
         default: stateNext = IDLE;
      endcase
      wrNext = stateNext inside {A_WS, A_WP, A_WH};
      aNext = wrNext || stateNext == A_RD;
      rdNext = stateNext inside {A_RD, B_RD};
      ramAddrNext = aNext ? ADDR_W'(aSel) : stateNext == B_RD ? ADDR_W'(bSel) : ramAddr;
      ramDataOutNext = wrNext ? dSel : ramDataOut;
      ramDataOeNext = wrNext;
      ramCe_nNext = !(aNext || stateNext == B_RD);
      ramOe_nNext = !rdNext;
      ramWe_nNext = stateNext != A_WP;
      stallNext = stateNext != DONE;
   end
   // state register, request latch in IDLE and read-data capture on the exiting edge of each read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         aLat <= '0;
         bLat <= '0;
         dLat <= '0;
         ramAddr <= '0;
         ramDataOut <= '0;
         ramDataOe <= 1'b0;
         ramCe_n <= 1'b1;
         ramOe_n <= 1'b1;
         ramWe_n <= 1'b1;
         stall <= 1'b1;
         AmemRead <= '0;
         BmemRead <= '0;
      end else begin
         state <= stateNext;
         cnt <= cntNext;
         aLat <= aSel;
         bLat <= bSel;
         dLat <= dSel;
         ramAddr <= ramAddrNext;
         ramDataOut <= ramDataOutNext;
         ramDataOe <= ramDataOeNext;
         ramCe_n <= ramCe_nNext;
         ramOe_n <= ramOe_nNext;
         ramWe_n <= ramWe_nNext;
         stall <= stallNext;
         if (state == A_RD) AmemRead <= bus.ramDataIn;
         if (state == B_RD) BmemRead <= bus.ramDataIn;
      end
   end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed CPU cycles against a cycle-timeline reference model and an SRAM model
module tb_sram_controller;
   localparam int AW = 18;
   localparam int WP = 2;
   typedef struct packed {logic [1:0] rw; logic [15:0] a, b, d;} txn_t;
   logic clk, rst;
   sram_controller_if #(.ADDR_W(AW)) bus();
   sram_controller #(.ADDR_W(AW), .WRITE_PULSE(WP)) dut(.clk(clk), .rst(rst), .bus(bus));
   logic [15:0] sram [0:65535];
   logic [15:0] modelMem [0:65535];
   txn_t q[$];
   int tests = 0, fails = 0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // asynchronous SRAM: combinational read, write on clocks where the write strobe is low
   assign bus.ramDataIn = (!bus.ramCe_n && !bus.ramOe_n) ? sram[bus.ramAddr[15:0]] : 16'hDEAD;
   always @(posedge clk) if (!bus.ramCe_n && !bus.ramWe_n && bus.ramDataOe) sram[bus.ramAddr[15:0]] <= bus.ramDataOut;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int cycLen(input logic [1:0] r);
      return r == 2'b01 ? 4 : r == 2'b10 ? 5 + WP : 3;
   endfunction
   // expected {stall, ramCe_n, ramOe_n, ramWe_n, ramDataOe} in clock k (1 = IDLE) of a cycle of length n
   function automatic logic [4:0] ctl(input txn_t t, input int k, input int n);
      if (k == n) return 5'b01110;
      if (k == 1) return 5'b11110;
      if (k == n - 1 || (t.rw == 2'b01 && k == 2)) return 5'b10010;
      return {3'b101, !(k >= 3 && k <= 2 + WP), 1'b1};
   endfunction
   // compare process: checks every clock of every queued CPU cycle against the timeline and memory model
   initial begin
      int k, n;
      txn_t t;
      logic [15:0] expA, expB;
      k = 0;
      expA = '0;
      expB = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            k = 0;
            expA = '0;
            expB = '0;
         end else if (q.size() != 0) begin
            k++;
            t = q[0];
            n = cycLen(t.rw);
            chk("weOeOverlap", 32'(!bus.ramWe_n && !bus.ramOe_n), 32'd0);
            chk("driveOeOverlap", 32'(bus.ramDataOe && !bus.ramOe_n), 32'd0);
            if (k <= n) chk($sformatf("ctl k=%0d", k), 32'({bus.stall, bus.ramCe_n, bus.ramOe_n, bus.ramWe_n, bus.ramDataOe}), 32'(ctl(t, k, n)));
            if (k == n - 1) chk("ramAddrB", 32'(bus.ramAddr), 32'(t.b));
            else if (k >= 2 && k <= n - 2) chk("ramAddrA", 32'(bus.ramAddr), 32'(t.a));
            if (t.rw == 2'b10 && k >= 2 && k <= n - 2) chk("ramDataOut", 32'(bus.ramDataOut), 32'(t.d));
            if (!bus.stall) begin
               chk("cycleLen", 32'(k), 32'(n));
               if (t.rw == 2'b10) modelMem[t.a] = t.d;
               if (t.rw == 2'b01) expA = modelMem[t.a];
               expB = modelMem[t.b];
               chk("AmemRead", 32'(bus.AmemRead), 32'(expA));
               chk("BmemRead", 32'(bus.BmemRead), 32'(expB));
               void'(q.pop_front());
               k = 0;
            end
         end
      end
   end
   // present one CPU request in IDLE and hold until the DONE->IDLE edge
   task automatic cpuCycle(input logic [1:0] r, input logic [15:0] a, input logic [15:0] b, input logic [15:0] d, input bit tog);
      int c;
      bus.rw = r;
      bus.Aaddr = a;
      bus.Baddr = b;
      bus.dataWrite = d;
      q.push_back('{r, a, b, d});
      c = 0;
      @(posedge clk);
      while (c < 40) begin
         @(negedge clk);
         if (!bus.stall) break;
         c++;
         if (tog) begin
            bus.rw = 2'($urandom);
            bus.Aaddr = 16'($urandom);
            bus.Baddr = 16'($urandom);
            bus.dataWrite = 16'($urandom);
         end
      end
      if (c >= 40) chk("stallTimeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
   endtask
   task automatic resetChecks(input string tag);
      chk({tag, ".stall"}, 32'(bus.stall), 32'd1);
      chk({tag, ".strobes"}, 32'({bus.ramCe_n, bus.ramOe_n, bus.ramWe_n}), 32'h7);
      chk({tag, ".ramDataOe"}, 32'(bus.ramDataOe), 32'd0);
      chk({tag, ".ramAddr"}, 32'(bus.ramAddr), 32'd0);
      chk({tag, ".ramDataOut"}, 32'(bus.ramDataOut), 32'd0);
      chk({tag, ".AmemRead"}, 32'(bus.AmemRead), 32'd0);
      chk({tag, ".BmemRead"}, 32'(bus.BmemRead), 32'd0);
   endtask
   // directed stimulus with hand-computed expectations
   initial begin
      int c;
      rst = 1'b0;
      bus.rw = 2'b00;
      bus.Aaddr = '0;
      bus.Baddr = '0;
      bus.dataWrite = '0;
      for (int i = 0; i < 65536; i++) begin
         sram[i] = 16'(i * 3 + 7);
         modelMem[i] = 16'(i * 3 + 7);
      end
      sram[16'h0010] = 16'h1234; modelMem[16'h0010] = 16'h1234;
      sram[16'h0011] = 16'h5A5A; modelMem[16'h0011] = 16'h5A5A;
      sram[16'h8000] = 16'hBEEF; modelMem[16'h8000] = 16'hBEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetChecks("reset");
      @(posedge clk);
      #1 rst = 1'b1;
      cpuCycle(2'b00, 16'h0000, 16'h0010, 16'h0000, 1'b0);
      chk("fetch0010", 32'(bus.BmemRead), 32'h1234);
      cpuCycle(2'b00, 16'hFFFF, 16'h0010, 16'h0000, 1'b0);
      cpuCycle(2'b01, 16'h8000, 16'h0011, 16'h0000, 1'b0);
      chk("load8000.A", 32'(bus.AmemRead), 32'hBEEF);
      chk("load8000.B", 32'(bus.BmemRead), 32'h5A5A);
      cpuCycle(2'b10, 16'h0100, 16'h0010, 16'hCAFE, 1'b0);
      chk("storeKeepsA", 32'(bus.AmemRead), 32'hBEEF);
      chk("storeSram", 32'(sram[16'h0100]), 32'hCAFE);
      cpuCycle(2'b01, 16'h0100, 16'h0011, 16'h0000, 1'b0);
      chk("load0100", 32'(bus.AmemRead), 32'hCAFE);
      cpuCycle(2'b11, 16'h0100, 16'h8000, 16'h1111, 1'b1);
      chk("rw11.B", 32'(bus.BmemRead), 32'hBEEF);
      chk("rw11.A", 32'(bus.AmemRead), 32'hCAFE);
      chk("rw11.noWrite", 32'(sram[16'h0100]), 32'hCAFE);
      cpuCycle(2'b10, 16'h0200, 16'h0200, 16'h7777, 1'b0);
      chk("storeThenFetch", 32'(bus.BmemRead), 32'h7777);
      bus.rw = 2'b10;
      bus.Aaddr = 16'h0300;
      bus.Baddr = 16'h0010;
      bus.dataWrite = 16'h9999;
      q.push_back('{2'b10, 16'h0300, 16'h0010, 16'h9999});
      c = 0;
      while (c < 20) begin
         @(negedge clk);
         if (!bus.ramWe_n) break;
         c++;
      end
      chk("wePulseSeen", 32'(bus.ramWe_n), 32'd0);
      #2 rst = 1'b0;
      q.delete();
      #1;
      resetChecks("midWriteReset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      cpuCycle(2'b01, 16'h8000, 16'h0010, 16'h0000, 1'b0);
      chk("afterReset.A", 32'(bus.AmemRead), 32'hBEEF);
      chk("afterReset.B", 32'(bus.BmemRead), 32'h1234);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side responder for the CPU's two memory ports: serves the data port (A: read/write per `rw`) and the instruction-fetch port (B: read-only) from one shared 16-bit asynchronous SRAM. It sits between the CPU top and the board SRAM pins. It serialises each CPU memory cycle into SRAM accesses, A first, then B. The CPU is held via `stall` until both results are valid.

## Interface
Parameters:
- `ADDR_W`, 18, SRAM address width (≥16); CPU addresses zero-extended.
- `WRITE_PULSE`, 1, cycles `ramWe_n` is held low per write (1–15).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `Aaddr`  in  16  data-port word address.
- `Baddr`  in  16  fetch-port word address.
- `dataWrite`  in  16  data-port write data.
- `rw`  in  2  data-port op: 00 none, 01 read, 10 write, 11 none.
- `AmemRead`  out  16  data-port read result.
- `BmemRead`  out  16  fetched instruction word.
- `stall`  out  1  1 = CPU must hold its state and inputs.
- `ramAddr`  out  ADDR_W  SRAM address.
- `ramDataOut`  out  16  SRAM write data.
- `ramDataIn`  in  16  SRAM read data.
- `ramDataOe`  out  1  1 = drive `ramDataOut` onto the pad bus.
- `ramCe_n`, `ramOe_n`, `ramWe_n`  out  1 each  SRAM chip enable, output enable and write enable (all active-low).

## Operation
- All outputs are registered. They are loaded on the edge that enters each state.
- States: IDLE, A_RD, A_WS (write setup), A_WP (write pulse), A_WH (write hold), B_RD, DONE.
- IDLE:
  - Latch `Aaddr`, `Baddr`, `dataWrite`, `rw`.
  - Next state: `rw`=01 → A_RD; `rw`=10 → A_WS; 00 or 11 → B_RD.
  - Inputs are ignored in every other state.
- A_RD:
  - Outputs: `ramAddr`=A, `ramCe_n`=0, `ramOe_n`=0, `ramWe_n`=1, `ramDataOe`=0.
  - Capture `ramDataIn` into `AmemRead` on the exiting edge.
  - Next state: B_RD.
- A_WS:
  - Outputs: `ramAddr`=A, `ramDataOut`=data, `ramDataOe`=1, `ramCe_n`=0, `ramOe_n`=1, `ramWe_n`=1.
  - Next state: A_WP. Load pulse counter with `WRITE_PULSE`-1.
- A_WP:
  - As A_WS but `ramWe_n`=0.
  - Stay while counter ≠ 0, decrementing each cycle. Then go to A_WH.
- A_WH:
  - As A_WS (`ramWe_n`=1; address and data still driven).
  - Next state: B_RD.
- B_RD:
  - Outputs: `ramAddr`=B, `ramDataOe`=0, `ramCe_n`=0, `ramOe_n`=0.
  - Capture `ramDataIn` into `BmemRead` on the exiting edge.
  - Next state: DONE.
- DONE:
  - `stall`=0 for exactly this cycle. `ramCe_n`=1, `ramOe_n`=1.
  - Next state: IDLE.
- `stall`=1 in every state except DONE.
- `AmemRead` changes only on an A_RD capture; it holds across writes and fetch-only cycles.
- `BmemRead` changes only on a B_RD capture.
- `ramWe_n`=0 never coincides with `ramOe_n`=0.
- `ramDataOe`=1 never coincides with `ramOe_n`=0.
- `ramAddr` = {(ADDR_W-16)'b0, address}.

## Timing
- Reset (`rst`=0, takes effect immediately):
  - State IDLE, counter 0.
  - `stall`=1, `ramCe_n`=`ramOe_n`=`ramWe_n`=1, `ramDataOe`=0.
  - `ramAddr`=0, `ramDataOut`=0, `AmemRead`=0, `BmemRead`=0.
- Reset mid-operation:
  - A write in progress is aborted; `ramWe_n` rises asynchronously.
  - The memory cycle restarts from IDLE after `rst` returns high.
- CPU cycle length, IDLE through DONE inclusive:
  - Fetch only: 3 clocks.
  - Read plus fetch: 4 clocks.
  - Write plus fetch: 5+`WRITE_PULSE` clocks.
- Read access window: one full clock. The address is stable from the state-entry edge to the capture edge.
- Write: address and data are stable ≥1 clock before `ramWe_n` falls and ≥1 clock after it rises. `ramWe_n` stays low exactly `WRITE_PULSE` clocks.
- `AmemRead` and `BmemRead` are valid in DONE. The CPU advances on the DONE→IDLE edge.

## Test plan
- Reset: hold `rst`=0 mid-sequence → `stall`=1; `ramCe_n`, `ramOe_n`, `ramWe_n` all 1; `ramDataOe`=0; `AmemRead`=`BmemRead`=0.
- Fetch: `rw`=00, `Baddr`=0x0010, SRAM[0x10]=0x1234 → `ramAddr`=0x00010 in B_RD; `BmemRead`=0x1234; `stall` low 1 clock in every 3.
- Load: `rw`=01, `Aaddr`=0x8000 (holds 0xBEEF), `Baddr`=0x0011 (holds 0x5A5A) → `AmemRead`=0xBEEF, `BmemRead`=0x5A5A, `stall` low on clock 4.
- Store with `WRITE_PULSE`=2: `rw`=10, `Aaddr`=0x0100, `dataWrite`=0xCAFE → `ramWe_n` low exactly 2 clocks, with address/data stable 1 clock either side. `AmemRead` unchanged. A following load of 0x0100 returns 0xCAFE.
- `rw`=11, plus `Aaddr`, `Baddr` and `rw` toggled while `stall`=1 → behaves as fetch of the address latched in IDLE; no SRAM write occurs.
- `rst` pulsed low during A_WP → `ramWe_n`=1 without waiting for a clock edge. After release: IDLE, then a normal cycle.
